prog_clock_divider: RTL and testbench

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

---
 rtl/prog_clock_divider.sv | 120 ++++++++++++
 tb/tb_prog_clock_divider.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider with shadowed divisor updates applied at period wrap.
// Optional macro PROG_CLKDIV_SYNC_EN adds a sync_req input that realigns all enabled channels.
module prog_clock_divider #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 4,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
`ifdef PROG_CLKDIV_SYNC_EN
  input  logic              sync_req,
`endif
  output logic              div_ready,
  output logic              wr_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam int PAD_N = 1 << CH_W;

  logic [NUM_CH-1:0] w_pend;
  logic [PAD_N-1:0]  w_pend_pad;
  logic              w_sync;
  logic              r_wr_err;

`ifdef PROG_CLKDIV_SYNC_EN
  assign w_sync = sync_req;
`else
  assign w_sync = 1'b0;
`endif

  // Non-existent channel selects read as "pending" so such writes are rejected.
  genvar gi;
  generate
    for (gi = 0; gi < PAD_N; gi++) begin : g_pad
      if (gi < NUM_CH) begin : g_real
        assign w_pend_pad[gi] = w_pend[gi];
      end else begin : g_none
        assign w_pend_pad[gi] = 1'b1;
      end
    end
  endgenerate

  assign div_ready = ~w_pend_pad[div_ch];
  assign wr_err    = r_wr_err;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_wr_err <= 1'b0;
    else     r_wr_err <= div_wr & ~div_ready;
  end

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt, r_div, r_shadow;
      logic [CNT_W-1:0] w_cnt_next, w_div_next, w_shadow_next, w_val_clamped;
      logic [CNT_W:0]   w_half;
      logic             r_pend, r_run, r_clk, r_tick;
      logic             w_pend_next, w_run_next, w_wr_hit, w_wrap, w_restart;

      assign w_wr_hit      = div_wr && div_ready && (div_ch == CH_W'(gi));
      assign w_val_clamped = (div_val <= CNT_W'(1)) ? CNT_W'(2) : div_val;
      assign w_wrap        = (r_cnt == r_div - CNT_W'(1));
      assign w_restart     = !r_run || w_sync;

      always_comb begin
        w_cnt_next    = r_cnt;
        w_div_next    = r_div;
        w_shadow_next = r_shadow;
        w_pend_next   = r_pend;
        w_run_next    = r_run;
        if (!ch_en[gi] || w_restart || w_wrap) begin
          // Every period boundary (wrap, restart, idle) is a safe point to adopt the shadow.
          w_cnt_next  = '0;
          w_run_next  = ch_en[gi];
          if (r_pend) w_div_next = r_shadow;
          w_pend_next = 1'b0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
        if (w_wr_hit) begin
          w_shadow_next = w_val_clamped;
          w_pend_next   = 1'b1;
        end
      end

      // Outputs are derived from next-state values so they line up with the registered count.
      assign w_half = ({1'b0, w_div_next} + (CNT_W+1)'(1)) >> 1;

      always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
          r_cnt    <= '0;
          r_div    <= CNT_W'(DEFAULT_DIV);
          r_shadow <= CNT_W'(DEFAULT_DIV);
          r_pend   <= 1'b0;
          r_run    <= 1'b0;
          r_clk    <= 1'b0;
          r_tick   <= 1'b0;
        end else begin
          r_cnt    <= w_cnt_next;
          r_div    <= w_div_next;
          r_shadow <= w_shadow_next;
          r_pend   <= w_pend_next;
          r_run    <= w_run_next;
          r_clk    <= ch_en[gi] && ({1'b0, w_cnt_next} >= w_half);
          r_tick   <= ch_en[gi] && (w_cnt_next == '0);
        end
      end

      assign w_pend[gi]  = r_pend;
      assign clk_out[gi] = r_clk;
      assign tick[gi]    = r_tick;
    end
  endgenerate

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider (4 channels, 16-bit divisors).
module tb_prog_clock_divider;

  logic        clk_in;
  logic        rst;
  logic [3:0]  ch_en;
  logic        div_wr;
  logic [1:0]  div_ch;
  logic [15:0] div_val;
  logic        sync_req;
  logic        div_ready;
  logic        wr_err;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  int n_cmp = 0;
  int n_err = 0;

  prog_clock_divider #(.NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(4)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .ch_en     (ch_en),
    .div_wr    (div_wr),
    .div_ch    (div_ch),
    .div_val   (div_val),
`ifdef PROG_CLKDIV_SYNC_EN
    .sync_req  (sync_req),
`endif
    .div_ready (div_ready),
    .wr_err    (wr_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step;
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ch_en = 4'h0; div_wr = 1'b0; div_ch = 2'd0; div_val = 16'd0; sync_req = 1'b0;
    #2;
    check("rst_clk_out", clk_out, 4'h0);
    check("rst_tick", tick, 4'h0);
    check("rst_wr_err", wr_err, 1'b0);
    step; step;
    rst = 1'b0; ch_en = 4'hF;
    step;
    // Default divisor 4: ticks on cnt 0, low for cnt 0..1, high for cnt 2..3
    for (int k = 0; k < 8; k++) begin
      check("def_clk", clk_out, (k % 4 >= 2) ? 4'hF : 4'h0);
      check("def_tick", tick, (k % 4 == 0) ? 4'hF : 4'h0);
      $display("default cycle %0d clk_out=%b tick=%b", k, clk_out, tick);
      step;
    end
    step;
    div_ch = 2'd1; div_val = 16'd7;
    check("ready_before_wr", div_ready, 1'b1);
    div_wr = 1'b1;
    step;
    div_wr = 1'b0;
    $display("write ch1 D=7 accepted");
    check("ready_pending", div_ready, 1'b0);
    check("ch1_period_intact_cnt2", clk_out[1], 1'b1);
    div_val = 16'd9; div_wr = 1'b1;
    step;
    div_wr = 1'b0;
    $display("write ch1 D=9 while pending, wr_err=%b", wr_err);
    check("wr_err_pulse", wr_err, 1'b1);
    check("ch1_period_intact_cnt3", clk_out[1], 1'b1);
    step;
    check("wr_err_one_cycle", wr_err, 1'b0);
    check("ready_after_wrap", div_ready, 1'b1);
    for (int k = 0; k < 14; k++) begin
      check("ch1_d7_clk", clk_out[1], (k % 7 >= 4) ? 1'b1 : 1'b0);
      check("ch1_d7_tick", tick[1], (k % 7 == 0) ? 1'b1 : 1'b0);
      check("ch0_undisturbed_clk", clk_out[0], (k % 4 >= 2) ? 1'b1 : 1'b0);
      check("ch0_undisturbed_tick", tick[0], (k % 4 == 0) ? 1'b1 : 1'b0);
      $display("ch1 D=7 cycle %0d clk_out=%b tick=%b", k, clk_out, tick);
      step;
    end
    div_ch = 2'd0; div_val = 16'd0; div_wr = 1'b1;
    step;
    div_wr = 1'b0;
    $display("write ch0 D=0 (clamp to 2)");
    step;
    for (int k = 0; k < 6; k++) begin
      check("ch0_d2_clk", clk_out[0], (k % 2 == 1) ? 1'b1 : 1'b0);
      check("ch0_d2_tick", tick[0], (k % 2 == 0) ? 1'b1 : 1'b0);
      $display("ch0 D=2 cycle %0d clk_out=%b tick=%b", k, clk_out, tick);
      step;
    end
    div_ch = 2'd2; div_val = 16'd9; div_wr = 1'b1;
    step;
    div_wr = 1'b0;
    #2 rst = 1'b1;
    #1;
    $display("async reset mid-period clk_out=%b tick=%b", clk_out, tick);
    check("async_rst_clk_out", clk_out, 4'h0);
    check("async_rst_tick", tick, 4'h0);
    check("async_rst_pend_cleared", div_ready, 1'b1);
    step;
    check("held_rst_clk_out", clk_out, 4'h0);
    step;
    rst = 1'b0;
    step;
    for (int k = 0; k < 8; k++) begin
      check("post_rst_clk", clk_out, (k % 4 >= 2) ? 4'hF : 4'h0);
      check("post_rst_tick", tick, (k % 4 == 0) ? 4'hF : 4'h0);
      $display("post-reset cycle %0d clk_out=%b tick=%b", k, clk_out, tick);
      step;
    end
    ch_en = 4'b0111;
    step;
    $display("ch3 disabled clk_out=%b tick=%b", clk_out, tick);
    check("dis_clk", clk_out, 4'h0);
    check("dis_tick", tick, 4'h0);
    step;
    check("dis_others_clk", clk_out, 4'b0111);
    ch_en = 4'hF;
    step;
    $display("ch3 re-enabled clk_out=%b tick=%b", clk_out, tick);
    check("reen_tick", tick, 4'b1000);
    check("reen_clk", clk_out, 4'b0111);
    step;
    check("reen_next_tick", tick, 4'b0111);
    check("reen_next_clk", clk_out, 4'h0);
`ifdef PROG_CLKDIV_SYNC_EN
    div_ch = 2'd0; div_val = 16'd3; div_wr = 1'b1;
    step;
    div_ch = 2'd1; div_val = 16'd5;
    step;
    div_wr = 1'b0;
    repeat (12) step;
    sync_req = 1'b1;
    step;
    sync_req = 1'b0;
    $display("sync pulse clk_out=%b tick=%b", clk_out, tick);
    check("sync_tick", tick, 4'hF);
    check("sync_clk", clk_out, 4'h0);
    step;
    check("sync_next_tick", tick, 4'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
